serial_to_parallel_buf: RTL and testbench

//   Collects a 1-bit serial stream into DATA_W-bit words and presents each word on a

---
 rtl/serial_to_parallel_buf.sv | 92 +++++++++
 tb/tb_serial_to_parallel_buf.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_buf.sv
// serial_to_parallel_buf
// Assembles a 1-bit serial stream into DATA_W-bit words and offers each
// finished word on a registered valid/ready output. The final bit of a word
// is held off upstream only while the output still holds an unaccepted word.
module serial_to_parallel_buf #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_a,
  input  logic              data_a,
  output logic              ready_a,
  output logic              valid_b,
  output logic [DATA_W-1:0] data_b,
  input  logic              ready_b,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [DATA_W-1:0] shift_next_s;
  logic              last_bit_s;
  logic              acc_s;
  logic              word_done_s;

  // Upstream handshake: only the word-completing bit can be stalled, and only
  // while the output slot is occupied and not being drained this cycle.
  always_comb begin
    last_bit_s  = (cnt_r == LAST_CNT);
    ready_a     = ~last_bit_s | ~valid_b | ready_b;
    acc_s       = valid_a & ready_a;
    word_done_s = acc_s & last_bit_s;
  end

  // Next assembly-register contents and bit count for an accepted bit.
  always_comb begin
    cnt_next_s   = cnt_r;
    shift_next_s = shift_r;
    if (acc_s) begin
      if (MSB_FIRST) begin
        shift_next_s = {shift_r[DATA_W-2:0], data_a};
      end else begin
        shift_next_s = {data_a, shift_r[DATA_W-1:1]};
      end
      if (word_done_s) begin
        cnt_next_s = CNT_ZERO;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_next_s   = cnt_r;
      shift_next_s = shift_r;
    end
  end

  // Assembly state; busy mirrors whether a partial word is held after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= CNT_ZERO;
      shift_r <= {DATA_W{1'b0}};
      busy    <= 1'b0;
    end else begin
      cnt_r   <= cnt_next_s;
      shift_r <= shift_next_s;
      busy    <= (cnt_next_s != CNT_ZERO);
    end
  end

  // Output word slot: load on completion (even while draining the previous
  // word, giving bubble-free back-to-back words), clear valid on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_b <= 1'b0;
      data_b  <= {DATA_W{1'b0}};
    end else if (word_done_s) begin
      valid_b <= 1'b1;
      data_b  <= shift_next_s;
    end else if (valid_b && ready_b) begin
      valid_b <= 1'b0;
    end else begin
      valid_b <= valid_b;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_buf.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share the serial
// stimulus; each has its own queue of hand-computed expected words.
module tb_serial_to_parallel_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_a;
  logic       data_a;
  logic       ready_b;
  logic       ready_a_m, valid_b_m, busy_m;
  logic       ready_a_l, valid_b_l, busy_l;
  logic [7:0] data_b_m, data_b_l;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         vcnt     = 0;
  bit         no_stall = 1'b0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  int         xfer_t[$];
  logic [7:0] exp_m, exp_l;
  int         gap_tbl[8] = '{0, 2, 1, 3, 0, 1, 2, 1};

  serial_to_parallel_buf #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .valid_a(valid_a), .data_a(data_a),
    .ready_a(ready_a_m), .valid_b(valid_b_m), .data_b(data_b_m),
    .ready_b(ready_b), .busy(busy_m)
  );

  serial_to_parallel_buf #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .valid_a(valid_a), .data_a(data_a),
    .ready_a(ready_a_l), .valid_b(valid_b_l), .data_b(data_b_l),
    .ready_b(ready_b), .busy(busy_l)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp output transfers.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a word transfers on the coming edge when valid_b & ready_b.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_b_m) vcnt++;
      if (valid_b_m && ready_b) begin
        checks++;
        xfer_t.push_back(cyc);
        if (q_m.size() == 0) begin
          failures++;
          $display("FAIL msb_unexpected_word got=%h expected=none", data_b_m);
        end else begin
          exp_m = q_m.pop_front();
          if (data_b_m !== exp_m) begin
            failures++;
            $display("FAIL msb_word got=%h expected=%h", data_b_m, exp_m);
          end
        end
      end
      if (valid_b_l && ready_b) begin
        checks++;
        if (q_l.size() == 0) begin
          failures++;
          $display("FAIL lsb_unexpected_word got=%h expected=none", data_b_l);
        end else begin
          exp_l = q_l.pop_front();
          if (data_b_l !== exp_l) begin
            failures++;
            $display("FAIL lsb_word got=%h expected=%h", data_b_l, exp_l);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  // Present one bit and wait (bounded) until it is accepted; returns at edge+1.
  task automatic send_bit(input logic b);
    int n = 0;
    valid_a = 1'b1;
    data_a  = b;
    @(negedge clk);
    if (no_stall) chk("ready_a_no_stall", ready_a_m, 1);
    while (!ready_a_m && n < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!ready_a_m) chk("bit_accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Send the first nbits of w, MSB first, optionally with idle gaps.
  task automatic send_word(input logic [7:0] w, input int nbits, input bit gapped);
    for (int i = 0; i < nbits; i++) begin
      if (gapped && gap_tbl[i] > 0) begin
        valid_a = 1'b0;
        repeat (gap_tbl[i]) begin @(posedge clk); #1; end
        chk("busy_in_gap", busy_m, (i != 0) ? 1 : 0);
      end
      send_bit(w[7-i]);
      chk("busy", busy_m, (i != 7) ? 1 : 0);
      if (i == 7) chk("valid_b_latency", valid_b_m, 1);
    end
    valid_a = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid_a = 1'b0; data_a = 1'b0; ready_b = 1'b1;
    #12;
    chk("rst_valid_b", valid_b_m, 0);
    chk("rst_data_b", data_b_m, 8'h00);
    chk("rst_busy", busy_m, 0);
    chk("rst_ready_a", ready_a_m, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tests 1+2: 0,1,1,0,0,1,0,0 -> MSB-first 64, LSB-first 26.
    vcnt = 0;
    q_m.push_back(8'h64); q_l.push_back(8'h26);
    send_word(8'h64, 8, 1'b0);
    idle(3);
    chk("t1_valid_pulse_cycles", vcnt, 1);

    // Test 3: stall the final bit of 3C behind an unaccepted A5.
    ready_b = 1'b0;
    q_m.push_back(8'hA5); q_l.push_back(8'hA5);
    send_word(8'hA5, 8, 1'b0);
    q_m.push_back(8'h3C); q_l.push_back(8'h3C);
    no_stall = 1'b1;
    send_word(8'h3C, 7, 1'b0);
    no_stall = 1'b0;
    valid_a = 1'b1; data_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_ready_a_stall", ready_a_m, 0);
      chk("t3_valid_b_hold", valid_b_m, 1);
      chk("t3_data_b_hold", data_b_m, 8'hA5);
      @(posedge clk); #1;
    end
    ready_b = 1'b1;
    @(negedge clk);
    chk("t3_ready_a_release", ready_a_m, 1);
    @(posedge clk); #1;
    valid_a = 1'b0;
    chk("t3_valid_b_after", valid_b_m, 1);
    chk("t3_data_b_after", data_b_m, 8'h3C);
    chk("t3_busy_after", busy_m, 0);
    idle(3);

    // Test 4: C3 with idle gaps between bits.
    q_m.push_back(8'hC3); q_l.push_back(8'hC3);
    send_word(8'hC3, 8, 1'b1);
    idle(3);

    // Test 5: reset after 3 bits discards them.
    send_word(8'hE0, 3, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_busy", busy_m, 0);
    chk("t5_rst_valid_b", valid_b_m, 0);
    chk("t5_rst_data_b", data_b_m, 8'h00);
    rst_n = 1'b1;
    idle(1);
    q_m.push_back(8'h81); q_l.push_back(8'h81);
    send_word(8'h81, 8, 1'b0);
    idle(3);

    // Test 6: four back-to-back words, no idle cycles.
    xfer_t.delete();
    no_stall = 1'b1;
    q_m.push_back(8'h01); q_l.push_back(8'h80);
    send_word(8'h01, 8, 1'b0);
    q_m.push_back(8'h02); q_l.push_back(8'h40);
    send_word(8'h02, 8, 1'b0);
    q_m.push_back(8'h80); q_l.push_back(8'h01);
    send_word(8'h80, 8, 1'b0);
    q_m.push_back(8'hFF); q_l.push_back(8'hFF);
    send_word(8'hFF, 8, 1'b0);
    no_stall = 1'b0;
    idle(3);
    chk("t6_xfer_count", xfer_t.size(), 4);
    if (xfer_t.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("t6_spacing", xfer_t[i] - xfer_t[i-1], 8);
    end

    idle(2);
    chk("q_m_drained", q_m.size(), 0);
    chk("q_l_drained", q_l.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
